// File: rtl/fruit_pkg.sv
// fruit_pkg: shared slot states, fruit type encoding, screen defaults and LFSR step.
package fruit_pkg;
   typedef enum logic [1:0] {IDLE, FLY, SLICED} slot_state_t;
   typedef enum logic [1:0] {APPLE = 2'd0, PEACH = 2'd1} fruit_type_t;
   localparam int DEF_SCREEN_H = 480;
   localparam int DEF_X_MIN    = 32;
   localparam int DEF_X_MAX    = 576;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps 16/14/13/11, shifting right so bit 0 is the oldest tap
   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction
endpackage

// File: rtl/fruit_slot.sv
// fruit_slot: one fruit's lifecycle FSM with ballistic motion and slice hold counter.
module fruit_slot
   import fruit_pkg::*;
#(
   parameter int FRUIT_SIZE = 32,
   parameter int V0         = 20,
   parameter int GRAVITY    = 1,
   parameter int SCREEN_H   = DEF_SCREEN_H,
   parameter int SLICE_HOLD = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_tick,
   input  logic        i_spawn,
   input  logic        i_slice,
   input  logic [9:0]  i_spawn_x,
   input  fruit_type_t i_spawn_type,
   output logic [9:0]  o_x,
   output logic [9:0]  o_y,
   output logic [1:0]  o_type,
   output logic        o_idle,
   output logic        o_active,
   output logic        o_sliced,
   output logic        o_hit,
   output logic        o_miss
);
   localparam logic signed [10:0] Y0   = 11'(SCREEN_H - FRUIT_SIZE);
   localparam logic signed [10:0] YLIM = 11'(SCREEN_H);
   localparam logic signed [6:0]  VY0  = 7'(-V0);
   localparam logic signed [6:0]  GR   = 7'(GRAVITY);
   localparam logic signed [6:0]  VMAX = 7'sd31;
   localparam logic [4:0]         HL   = 5'(SLICE_HOLD - 1);

   slot_state_t        r_state;
   fruit_type_t        r_type;
   logic [9:0]         r_x;
   logic signed [10:0] r_y;
   logic signed [6:0]  r_vy;
   logic [4:0]         r_hold;
   logic               r_hit, r_miss;
   logic signed [10:0] w_y_next;
   logic signed [6:0]  w_vy_next;
   logic               w_exit;

   assign w_y_next  = r_y + {{4{r_vy[6]}}, r_vy};
   assign w_vy_next = (r_vy > VMAX - GR) ? VMAX : r_vy + GR;
   assign w_exit    = (r_vy > 7'sd0) && (w_y_next >= YLIM);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_type  <= APPLE;
         r_x     <= '0;
         r_y     <= '0;
         r_vy    <= '0;
         r_hold  <= '0;
         r_hit   <= 1'b0;
         r_miss  <= 1'b0;
      end else begin
         r_hit  <= 1'b0;
         r_miss <= 1'b0;
         case (r_state)
            IDLE: if (i_spawn) begin
               r_state <= FLY;
               r_x     <= i_spawn_x;
               r_y     <= Y0;
               r_vy    <= VY0;
               r_type  <= i_spawn_type;
               r_hold  <= '0;
            end
            // a slice in the same cycle as a frame tick freezes the fruit before it moves
            FLY: if (i_slice) begin
               r_state <= SLICED;
               r_hit   <= 1'b1;
            end else if (i_tick) begin
               r_y  <= w_y_next;
               r_vy <= w_vy_next;
               if (w_exit) begin
                  r_state <= IDLE;
                  r_miss  <= 1'b1;
               end
            end
            SLICED: if (i_tick) begin
               r_hold <= (r_hold == HL) ? '0 : r_hold + 5'd1;
               if (r_hold == HL) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_x      = r_x;
   assign o_y      = r_y[9:0];
   assign o_type   = r_type;
   assign o_idle   = r_state == IDLE;
   assign o_active = r_state != IDLE;
   assign o_sliced = r_state == SLICED;
   assign o_hit    = r_hit;
   assign o_miss   = r_miss;
endmodule

// File: rtl/fruit_scheduler.sv
// fruit_scheduler: spawn cadence, LFSR placement and slot pool for on-screen fruits.
module fruit_scheduler
   import fruit_pkg::*;
#(
   parameter int NUM_SLOTS    = 4,
   parameter int SPAWN_PERIOD = 90,
   parameter int FRUIT_SIZE   = 32,
   parameter int V0           = 20,
   parameter int GRAVITY      = 1,
   parameter int SCREEN_H     = DEF_SCREEN_H,
   parameter int X_MIN        = DEF_X_MIN,
   parameter int X_MAX        = DEF_X_MAX,
   parameter int SLICE_HOLD   = 16
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic                                 i_frame_tick,
   input  logic                                 i_slice_valid,
   input  logic [$clog2(NUM_SLOTS)-1:0]         i_slice_slot,
   output logic [NUM_SLOTS-1:0][9:0]            o_fruit_x,
   output logic [NUM_SLOTS-1:0][9:0]            o_fruit_y,
   output logic [9:0]                           o_fruit_s,
   output logic [NUM_SLOTS-1:0][1:0]            o_fruit_type,
   output logic [NUM_SLOTS-1:0]                 o_fruit_active,
   output logic [NUM_SLOTS-1:0]                 o_fruit_sliced,
   output logic                                 o_hit_pulse,
   output logic                                 o_miss_pulse
);
   localparam int CW = $clog2(SPAWN_PERIOD);
   localparam int SW = $clog2(NUM_SLOTS);

   logic [CW-1:0]        r_spawn_cnt;
   logic [15:0]          r_lfsr;
   logic [NUM_SLOTS-1:0] w_idle, w_spawn, w_hit, w_miss;
   logic                 w_spawn_due;
   logic [9:0]           w_off, w_spawn_x;
   fruit_type_t          w_type;

   assign w_spawn_due = i_frame_tick && (r_spawn_cnt == CW'(SPAWN_PERIOD - 1));
   // isolate the lowest idle slot; slots retiring on this edge are not yet idle
   assign w_spawn     = w_spawn_due ? (w_idle & (~w_idle + NUM_SLOTS'(1))) : '0;
   assign w_off       = {1'b0, r_lfsr[8:0]};
   assign w_spawn_x   = (w_off > 10'(X_MAX - X_MIN)) ? 10'(X_MIN) + w_off - 10'd256 : 10'(X_MIN) + w_off;
   assign w_type      = r_lfsr[9] ? PEACH : APPLE;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_spawn_cnt <= '0;
         r_lfsr      <= LFSR_SEED;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
         if (i_frame_tick) r_spawn_cnt <= w_spawn_due ? '0 : r_spawn_cnt + CW'(1);
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      fruit_slot #(
         .FRUIT_SIZE (FRUIT_SIZE),
         .V0         (V0),
         .GRAVITY    (GRAVITY),
         .SCREEN_H   (SCREEN_H),
         .SLICE_HOLD (SLICE_HOLD)
      ) u_slot (
         .i_clk        (i_clk),
         .i_rst_n      (i_rst_n),
         .i_tick       (i_frame_tick),
         .i_spawn      (w_spawn[g]),
         .i_slice      (i_slice_valid && (i_slice_slot == SW'(g))),
         .i_spawn_x    (w_spawn_x),
         .i_spawn_type (w_type),
         .o_x          (o_fruit_x[g]),
         .o_y          (o_fruit_y[g]),
         .o_type       (o_fruit_type[g]),
         .o_idle       (w_idle[g]),
         .o_active     (o_fruit_active[g]),
         .o_sliced     (o_fruit_sliced[g]),
         .o_hit        (w_hit[g]),
         .o_miss       (w_miss[g])
      );
   end

   assign o_fruit_s    = 10'(FRUIT_SIZE);
   assign o_hit_pulse  = |w_hit;
   assign o_miss_pulse = |w_miss;
endmodule

// File: tb/tb_fruit_scheduler.sv
// tb_fruit_scheduler: two schedulers (spawn period 90 and 10) checked against a frame-level model.
module tb_fruit_scheduler;
   logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, slice_valid = 1'b0;
   logic [1:0] slice_slot = 2'd0;
   logic [3:0][9:0] fx [2];
   logic [3:0][9:0] fy [2];
   logic [3:0][1:0] ftyp [2];
   logic [3:0] fa [2];
   logic [3:0] fsl [2];
   logic [9:0] fs [2];
   logic hp [2];
   logic mp [2];

   always #5 clk = ~clk;

   fruit_scheduler dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(frame_tick), .i_slice_valid(slice_valid),
      .i_slice_slot(slice_slot), .o_fruit_x(fx[0]), .o_fruit_y(fy[0]), .o_fruit_s(fs[0]),
      .o_fruit_type(ftyp[0]), .o_fruit_active(fa[0]), .o_fruit_sliced(fsl[0]),
      .o_hit_pulse(hp[0]), .o_miss_pulse(mp[0]));

   fruit_scheduler #(.SPAWN_PERIOD(10)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(frame_tick), .i_slice_valid(slice_valid),
      .i_slice_slot(slice_slot), .o_fruit_x(fx[1]), .o_fruit_y(fy[1]), .o_fruit_s(fs[1]),
      .o_fruit_type(ftyp[1]), .o_fruit_active(fa[1]), .o_fruit_sliced(fsl[1]),
      .o_hit_pulse(hp[1]), .o_miss_pulse(mp[1]));

   // model: state 0 idle, 1 flying, 2 sliced
   int sp [2] = '{90, 10};
   int m_st [2][4], m_x [2][4], m_y [2][4], m_vy [2][4], m_ty [2][4], m_hold [2][4];
   int m_cnt [2];
   int m_hit [2], m_miss [2];
   int m_lfsr;
   int n_cmp = 0, n_bad = 0;

   typedef struct {int k; int y;} fl_t;
   fl_t tbl [8];

   task automatic chk(input string nm, input int d, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s [dut%0d]: got %0d, expected %0d", nm, d, act, exp);
      end
   endtask

   function automatic int lstep(input int l);
      int b;
      b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      return (l >> 1) | (b << 15);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0; m_hit[d] = 0; m_miss[d] = 0;
         for (int i = 0; i < 4; i++) begin
            m_st[d][i] = 0; m_x[d][i] = 0; m_y[d][i] = 0; m_vy[d][i] = 0; m_ty[d][i] = 0; m_hold[d][i] = 0;
         end
      end
      m_lfsr = 16'hACE1;
   endtask

   task automatic model(input int d, input bit ft, input bit sv, input int ss);
      int idle [4];
      int k, yn, off;
      for (int i = 0; i < 4; i++) idle[i] = (m_st[d][i] == 0) ? 1 : 0;
      m_hit[d] = 0; m_miss[d] = 0;
      for (int i = 0; i < 4; i++) begin
         if (m_st[d][i] == 1 && sv && ss == i) begin
            m_st[d][i] = 2; m_hold[d][i] = 0; m_hit[d] = 1;
         end else if (m_st[d][i] == 1 && ft) begin
            yn = m_y[d][i] + m_vy[d][i];
            if (m_vy[d][i] > 0 && yn >= 480) begin
               m_st[d][i] = 0; m_miss[d] = 1;
            end else begin
               m_y[d][i] = yn;
               m_vy[d][i] = (m_vy[d][i] + 1 > 31) ? 31 : m_vy[d][i] + 1;
            end
         end else if (m_st[d][i] == 2 && ft) begin
            m_hold[d][i]++;
            if (m_hold[d][i] >= 16) m_st[d][i] = 0;
         end
      end
      if (ft) begin
         if (m_cnt[d] == sp[d] - 1) begin
            m_cnt[d] = 0;
            k = -1;
            for (int i = 3; i >= 0; i--) if (idle[i] != 0) k = i;
            if (k >= 0) begin
               off = m_lfsr & 511;
               m_st[d][k] = 1; m_y[d][k] = 448; m_vy[d][k] = -20;
               m_x[d][k] = (off > 544) ? 32 + off - 256 : 32 + off;
               m_ty[d][k] = (m_lfsr >> 9) & 1;
            end
         end else m_cnt[d]++;
      end
   endtask

   task automatic compare(input int d);
      int am, sm;
      am = 0; sm = 0;
      for (int i = 0; i < 4; i++) begin
         if (m_st[d][i] != 0) am |= 1 << i;
         if (m_st[d][i] == 2) sm |= 1 << i;
      end
      chk("active", d, int'(fa[d]), am);
      chk("sliced", d, int'(fsl[d]), sm);
      chk("hit_pulse", d, int'(hp[d]), m_hit[d]);
      chk("miss_pulse", d, int'(mp[d]), m_miss[d]);
      for (int i = 0; i < 4; i++) if (m_st[d][i] != 0) begin
         chk("fruit_x", d, int'(fx[d][i]), m_x[d][i]);
         chk("fruit_y", d, int'(fy[d][i]), m_y[d][i] & 1023);
         chk("fruit_type", d, int'(ftyp[d][i]), m_ty[d][i]);
      end
   endtask

   // entered and left on a falling clock edge
   task automatic step(input bit ft, input bit sv, input int ss);
      frame_tick = ft; slice_valid = sv; slice_slot = 2'(ss);
      @(posedge clk);
      model(0, ft, sv, ss);
      model(1, ft, sv, ss);
      m_lfsr = lstep(m_lfsr);
      #1;
      compare(0);
      compare(1);
      @(negedge clk);
   endtask

   task automatic tick(input bit sv, input int ss);
      step(0, 0, 0);
      step(1, sv, ss);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_active", d, int'(fa[d]), 0);
         chk("rst_sliced", d, int'(fsl[d]), 0);
         chk("rst_pulses", d, int'({hp[d], mp[d]}), 0);
         chk("rst_x_zero", d, int'(fx[d] == '0), 1);
         chk("rst_y_zero", d, int'(fy[d] == '0), 1);
         chk("rst_type_zero", d, int'(ftyp[d] == '0), 1);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int j, y2, nm;
      tbl[0] = '{1, 428};  tbl[1] = '{2, 409};  tbl[2] = '{3, 391};  tbl[3] = '{20, 238};
      tbl[4] = '{21, 238}; tbl[5] = '{22, 239}; tbl[6] = '{23, 241}; tbl[7] = '{42, 469};
      @(negedge clk);
      do_reset();
      chk("fruit_s", 0, int'(fs[0]), 32);
      chk("fruit_s", 1, int'(fs[1]), 32);

      for (int t = 1; t <= 89; t++) begin
         tick(0, 0);
         if (t == 50) chk("b_full_drop", 1, int'(fa[1]), 15);
      end
      chk("a_idle_89", 0, int'(fa[0]), 0);
      tick(0, 0);
      chk("a_spawn_90", 0, int'(fa[0]), 1);
      chk("a_spawn_y", 0, int'(fy[0][0]), 448);
      chk("a_spawn_x_range", 0, int'(fx[0][0] >= 10'd32 && fx[0][0] <= 10'd576), 1);

      j = 0;
      for (int k = 1; k <= 42; k++) begin
         tick(0, 0);
         if (j < 8 && tbl[j].k == k) begin
            chk($sformatf("a_flight_y_k%0d", k), 0, int'(fy[0][0]), tbl[j].y);
            j++;
         end
      end

      tick(1, 0);
      chk("a_slice_exit_hit", 0, int'(hp[0]), 1);
      chk("a_slice_exit_miss", 0, int'(mp[0]), 0);
      chk("a_slice_exit_sliced", 0, int'(fsl[0][0]), 1);
      chk("a_slice_exit_y", 0, int'(fy[0][0]), 469);
      for (int n = 1; n <= 16; n++) begin
         tick(0, 0);
         if (n == 15) chk("a_hold_15", 0, int'(fa[0][0]), 1);
         if (n == 16) chk("a_hold_16", 0, int'(fa[0][0]), 0);
      end

      for (int n = 0; n < 40 && m_st[1][2] != 1; n++) tick(0, 0);
      chk("b_s2_flying", 1, int'(fa[1][2] && !fsl[1][2]), 1);
      y2 = int'(fy[1][2]);
      step(0, 1, 2);
      chk("b_s2_hit", 1, int'(hp[1]), 1);
      chk("b_s2_sliced", 1, int'(fsl[1][2]), 1);
      chk("a_idle_slice_nohit", 0, int'(hp[0]), 0);
      for (int n = 1; n <= 16; n++) begin
         tick(0, 0);
         if (n == 1) chk("b_s2_frozen", 1, int'(fy[1][2]), y2);
         if (n == 16) chk("b_s2_retired", 1, int'(fa[1][2]), 0);
      end

      nm = 0;
      for (int n = 0; n < 60; n++) begin
         tick(0, 0);
         nm += int'(mp[0]);
      end
      chk("a_miss_once", 0, nm, 1);
      chk("a_after_miss_idle", 0, int'(fa[0][0]), 0);

      do_reset();
      step(0, 0, 0);
      chk("release_no_pulse", 1, int'({hp[1], mp[1]}), 0);
      for (int t = 1; t <= 89; t++) tick(0, 0);
      chk("a_idle_89_rst", 0, int'(fa[0]), 0);
      tick(0, 0);
      chk("a_spawn_90_rst", 0, int'(fa[0]), 1);

      for (int n = 0; n < 500; n++) begin
         for (int g = 0; g < 1 + int'($urandom_range(2)); g++)
            step(0, ($urandom % 6) == 0, int'($urandom_range(3)));
         step(1, ($urandom % 8) == 0, int'($urandom_range(3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fruit_scheduler.md
# fruit_scheduler

Owns the lifecycle of every on-screen fruit: spawns fruits into a fixed pool of slots on a frame cadence, advances each fruit's ballistic motion once per frame, and retires fruits when they are sliced or fall off screen. Its per-slot position, type and active outputs feed the colour mapper's sprite-enable and priority logic, replacing free-running per-fruit movers with one sequenced resource.

## Interface
- NUM_SLOTS, 4: fruit slots; slot 0 has highest draw priority.
- SPAWN_PERIOD, 90: frame ticks between spawn attempts.
- FRUIT_SIZE, 32: sprite edge in pixels, driven on fruit_s.
- V0, 20: launch speed in pixels/frame, upward.
- GRAVITY, 1: added to vertical velocity each frame.
- SCREEN_H, 480; X_MIN, 32; X_MAX, 576: spawn bounds.
- SLICE_HOLD, 16: frames a sliced fruit stays visible.
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, at vsync start
- slice_valid  in  1  slice request, one cycle
- slice_slot  in  $clog2(NUM_SLOTS)  slot being sliced
- fruit_x, fruit_y  out  NUM_SLOTS x 10  top-left corner per slot
- fruit_s  out  10  constant FRUIT_SIZE
- fruit_type  out  NUM_SLOTS x 2  sprite select (0 apple, 1 peach, 2–3 reserved)
- fruit_active  out  NUM_SLOTS  slot is drawable (FLY or SLICED)
- fruit_sliced  out  NUM_SLOTS  slot is in SLICED
- hit_pulse, miss_pulse  out  1  one-cycle event strobes

## Operation
- Per-slot FSM: IDLE -> FLY on spawn; FLY -> SLICED on a valid slice; FLY -> IDLE on exit (miss); SLICED -> IDLE after SLICE_HOLD frame ticks.
- Spawn counter increments on each frame_tick. On the tick where it equals SPAWN_PERIOD-1, it wraps to 0 and a spawn is attempted into the lowest-index IDLE slot. If no slot is IDLE, the spawn is dropped silently.
- Spawn values:
  - y = SCREEN_H - FRUIT_SIZE (448); vy = -V0.
  - off = lfsr[8:0]; x = X_MIN + off, or X_MIN + off - 256 if off > X_MAX - X_MIN.
  - type = {1'b0, lfsr[9]}.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11, shifts every Clk, seed 16'hACE1, never all-zero.
- Motion in FLY, on each frame_tick: y_next = y + vy, where y is 11-bit signed internally and vy is 7-bit signed; then vy = min(vy + GRAVITY, +31).
- Exit: if vy > 0 and y_next >= SCREEN_H, the slot goes to IDLE and miss_pulse fires. The fruit_y output is the low 10 bits of y.
- Slice: if slice_valid and the addressed slot is in FLY, the slot goes to SLICED, hit_pulse fires, and position freezes. A slice addressed to any other state is ignored, with no pulse.
- SLICED: a hold counter counts frame ticks; at SLICE_HOLD it goes to IDLE, with no pulse.
- Simultaneous events:
  - slice_valid and frame_tick on the same slot in the same cycle: slice wins; no motion update and no miss.
  - Spawn into a slot in the same cycle it retires: not allowed; only slots already IDLE at that edge are eligible.
  - At most one miss_pulse and one hit_pulse per cycle. If several slots miss on one tick, miss_pulse is asserted once; the count is not preserved.

## Timing
- All outputs are registered. Motion, spawn and retire results are visible the cycle after frame_tick.
- hit_pulse is asserted the cycle after slice_valid; miss_pulse the cycle after frame_tick.
- Reset values:
  - all slots IDLE; fruit_x = fruit_y = 0; fruit_type = 0;
  - fruit_active = fruit_sliced = 0; pulses 0;
  - spawn and hold counters 0; LFSR = seed.
- Reset mid-flight: all slots are cleared immediately (asynchronous), and no pulse is emitted on release.
- frame_tick must be separated by at least 2 Clk cycles. Slot updates complete within one cycle.

## Structure
- Package fruit_pkg holds:
  - typedef enum slot_state_t {IDLE, FLY, SLICED};
  - the fruit_type encoding;
  - the default SCREEN_H, X_MIN and X_MAX constants.
- Sub-module fruit_slot is the per-slot FSM plus motion and hold counter, with a spawn-load interface and an exit/hit strobe. It is instantiated NUM_SLOTS times via generate.
- The top level holds the spawn counter, LFSR, free-slot priority encoder, and slice decode/pulse OR.

## Test plan
- Reset then 89 frame_ticks -> all fruit_active = 0. 90th tick -> fruit_active = 4'b0001, fruit_y[0] = 448, fruit_x[0] in [32,576].
- Free flight of slot 0, unsliced -> y sequence 448, 428, 409, …; apex near 238. miss_pulse exactly once when y ≥ 480; slot returns to IDLE.
- All 4 slots flying when a spawn is due -> spawn dropped; active stays 4'b1111; no slot's state is corrupted.
- slice_valid with slice_slot = 2 while slot 2 is in FLY -> hit_pulse 1 cycle later, fruit_sliced[2] = 1, y frozen. After 16 ticks, fruit_active[2] = 0. Slicing an IDLE slot -> no hit_pulse.
- slice_valid coincident with the frame_tick that would make slot 0 exit -> hit_pulse, no miss_pulse, slot 0 in SLICED.
- Reset_n asserted mid-flight with 3 slots active -> all outputs 0 asynchronously. After release, the first spawn occurs exactly 90 ticks later.
